sdio_dat_tx: RTL
================

SDIO_DAT_TX -- requirements
Module: sdio_dat_tx

Interface
REQ-001 Parameter BLOCK_MAX, default 512, largest block in bytes; block_size 0 encodes BLOCK_MAX.
REQ-002 clk  in  1  single clock for all logic.
REQ-003 rst  in  1  reset, synchronous and active-high; the block has one clock.
REQ-004 start  in  1  single-cycle request to send one block; sampled only in IDLE.
REQ-005 block_size  in  10  byte count 1..512; sampled with start.
REQ-006 data  in  8  next payload byte, MSB sent first.
REQ-007 data_valid  in  1  data holds a byte.
REQ-008 data_ready  out  1  byte accepted this cycle when data_valid is also high.
REQ-009 sdio_dat  out  1  DAT0 drive value, registered.
REQ-010 sdio_dat_oe  out  1  DAT0 output enable, registered.
REQ-011 busy  out  1  high in any state other than IDLE.
REQ-012 done  out  1  one-cycle pulse after the end bit of a good block.
REQ-013 underrun  out  1  one-cycle pulse when a block is aborted for lack of data.

Function
REQ-014 The FSM states are IDLE, START, DATA, CRC, END.
- IDLE->START on start.
- START->DATA after 1 cycle.
- DATA->CRC after 8*N bit cycles.
- CRC->END after 16 cycles.
- END->IDLE after 1 cycle.
REQ-015 Frame timing: start sampled at edge k -> start bit (0) is on sdio_dat with sdio_dat_oe=1 from edge k+1; the frame is 1+8N+16+1 contiguous cycles with oe=1.
REQ-016 Data bits are sent MSB first; byte i+1 follows byte i with no gap.
REQ-017 data_ready is high for exactly one cycle per byte, in the cycle before that byte's first bit is needed (first byte during START); N handshakes occur per block.
REQ-018 If data_valid is low in a cycle that requires a byte:
- underrun pulses next cycle.
- sdio_dat_oe drops to 0 and sdio_dat to 1 on the same edge.
- the FSM returns to IDLE; done does not pulse.
REQ-019 CRC is CRC16-CCITT (x^16+x^12+x^5+1, seed 0x0000), computed over payload bits only, excluding the start bit.
REQ-020 The CRC is sent MSB first in state CRC; the engine is not clocked during CRC.
REQ-021 The end bit is 1 with oe=1.
REQ-022 done pulses in the first IDLE cycle, coincident with oe=0.
REQ-023 start while busy is ignored.
REQ-024 block_size and data are not re-sampled mid-block, except data on each handshake.
REQ-025 The byte counter is 10 bits; block_size 0 yields 512 bytes.
REQ-026 The bit counter wraps 7->0 on each byte.
REQ-027 The CRC counter counts 15->0.
REQ-028 In IDLE, sdio_dat=1, sdio_dat_oe=0 and data_ready=0.

Reset
REQ-029 On rst, the next state is IDLE and outputs are set as follows:
- sdio_dat=1, sdio_dat_oe=0.
- busy=0, done=0, underrun=0, data_ready=0.
- all counters 0.
REQ-030 rst asserted mid-frame aborts within one edge with no done or underrun pulse.
REQ-031 The CRC engine is held in reset whenever rst is high or the FSM is in IDLE.

Structure
REQ-032 The shared SDIO package holds:
- the state enum.
- CRC16_POLY=16'h1021 and CRC16_SEED=16'h0000.
- the START_BIT=0 and END_BIT=1 constants.
REQ-033 One sub-module: the team's existing crc16, bit-serial.
- en is high only in DATA.
- the input bit is the payload bit being loaded to sdio_dat.
- the module is parameterised from the package constants.

Verification
REQ-034 "123456789" ASCII, block_size 9, data_valid always high -> the frame is the following, with done on the following cycle:
- start bit 0.
- 72 payload bits.
- CRC 0x31C3.
- end bit 1.
- 90 oe cycles in total.
REQ-035 512 bytes 0xFF, block_size 0 -> CRC bits 0x7FA1, 4114 oe cycles, 512 data_ready handshakes.
REQ-036 1 byte 0x00, block_size 1 -> frame 0, 00000000, 16 zero bits, 1; done pulses.
REQ-037 4-byte block, data_valid dropped before byte 3 -> after the 16th payload bit:
- underrun pulses.
- oe falls.
- no CRC bits are sent.
- the next block sends the correct CRC.
REQ-038 rst asserted in the middle of the CRC state -> next cycle oe=0, dat=1, busy=0, no done; a fresh block then gives the correct CRC.
REQ-039 start pulsed during DATA -> ignored; frame length and CRC are unchanged.

Source files
------------

// File: rtl/sdio_dat_tx_pkg.sv
// sdio_dat_tx_pkg: shared SDIO DAT-line types and constants
package sdio_dat_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, CRC, END} state_t;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_SEED = 16'h0000;
    localparam logic START_BIT = 1'b0;
    localparam logic END_BIT = 1'b1;
endpackage

// File: rtl/sdio_dat_tx_crc16.sv
// sdio_dat_tx_crc16: bit-serial CRC16 with a combinational look-ahead of the next value
module sdio_dat_tx_crc16
    import sdio_dat_tx_pkg::*;
#(
    parameter logic [15:0] POLY = CRC16_POLY,
    parameter logic [15:0] SEED = CRC16_SEED
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc,
    output logic [15:0] crc_next
);
    // next remainder after shifting in din; exposed so the sender can use it before it lands
    always_comb crc_next = {crc[14:0], 1'b0} ^ ((din ^ crc[15]) ? POLY : 16'h0000);

    // remainder register, cleared to the seed whenever the engine is held in reset
    always_ff @(posedge clk)
        if (rst) crc <= SEED;
        else if (en) crc <= crc_next;
endmodule

// File: rtl/sdio_dat_tx.sv
// sdio_dat_tx: serialises one data block onto SDIO DAT0 with start bit, CRC16 and end bit
module sdio_dat_tx
    import sdio_dat_tx_pkg::*;
#(
    parameter int BLOCK_MAX = 512
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [9:0] block_size,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       sdio_dat,
    output logic       sdio_dat_oe,
    output logic       busy,
    output logic       done,
    output logic       underrun
);
    state_t      state, state_n;
    logic        dat_n, oe_n, done_n, und_n;
    logic [9:0]  byte_cnt, byte_n;
    logic [2:0]  bit_cnt, bit_n;
    logic [3:0]  crc_cnt, crc_cnt_n;
    logic [6:0]  sh, sh_n;
    logic [15:0] crc, crc_next;

    // the engine sees each payload bit while it is on the line, and idles outside DATA
    sdio_dat_tx_crc16 #(.POLY(CRC16_POLY), .SEED(CRC16_SEED)) u_crc (
        .clk(clk),
        .rst(rst || state == IDLE),
        .en(state == DATA),
        .din(sdio_dat),
        .crc(crc),
        .crc_next(crc_next)
    );

    assign busy = state != IDLE;
    assign data_ready = state == START || (state == DATA && bit_cnt == '0 && byte_cnt != '0);

    // next-state and next-output logic; every line value is decided one edge ahead
    always_comb begin
        state_n = state;
        dat_n = sdio_dat;
        oe_n = sdio_dat_oe;
        done_n = 1'b0;
        und_n = 1'b0;
        byte_n = byte_cnt;
        bit_n = bit_cnt;
        crc_cnt_n = crc_cnt;
        sh_n = sh;
        case (state)
            IDLE: if (start) begin
                state_n = START;
                dat_n = START_BIT;
                oe_n = 1'b1;
                byte_n = block_size == '0 ? 10'(BLOCK_MAX) : block_size;
            end
            START, DATA: if (data_ready) begin
                if (data_valid) begin
                    state_n = DATA;
                    dat_n = data[7];
                    sh_n = data[6:0];
                    bit_n = 3'd7;
                    byte_n = byte_cnt - 10'd1;
                end else begin
                    state_n = IDLE;
                    dat_n = 1'b1;
                    oe_n = 1'b0;
                    und_n = 1'b1;
                end
            end else if (bit_cnt == '0) begin
                state_n = CRC;
                dat_n = crc_next[15];
                crc_cnt_n = 4'd15;
            end else begin
                dat_n = sh[6];
                sh_n = {sh[5:0], 1'b0};
                bit_n = bit_cnt - 3'd1;
            end
            CRC: if (crc_cnt == '0) begin
                state_n = END;
                dat_n = END_BIT;
            end else begin
                dat_n = crc[crc_cnt - 4'd1];
                crc_cnt_n = crc_cnt - 4'd1;
            end
            END: begin
                state_n = IDLE;
                dat_n = 1'b1;
                oe_n = 1'b0;
                done_n = 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end

    // state, line drivers, pulses and counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            sdio_dat <= 1'b1;
            sdio_dat_oe <= 1'b0;
            done <= 1'b0;
            underrun <= 1'b0;
            byte_cnt <= '0;
            bit_cnt <= '0;
            crc_cnt <= '0;
            sh <= '0;
        end else begin
            state <= state_n;
            sdio_dat <= dat_n;
            sdio_dat_oe <= oe_n;
            done <= done_n;
            underrun <= und_n;
            byte_cnt <= byte_n;
            bit_cnt <= bit_n;
            crc_cnt <= crc_cnt_n;
            sh <= sh_n;
        end
    end
endmodule
